// File: rtl/mu0_pkg.sv
// Shared MU0 controller definitions: opcodes, ALU function codes, FSM states
// and the packed control-word bundle driven towards the datapath.
package mu0_pkg;

  localparam int unsigned OPW   = 4;
  localparam int unsigned ALUW  = 2;
  localparam int unsigned WAITW = 8;
  localparam int unsigned ICW   = 16;

  localparam logic [OPW-1:0] OP_LDA = OPW'(0);
  localparam logic [OPW-1:0] OP_STA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4);
  localparam logic [OPW-1:0] OP_JGE = OPW'(5);
  localparam logic [OPW-1:0] OP_JNE = OPW'(6);
  localparam logic [OPW-1:0] OP_STP = OPW'(7);

  localparam logic [ALUW-1:0] ALU_PASSB = 2'b00;
  localparam logic [ALUW-1:0] ALU_ADD   = 2'b01;
  localparam logic [ALUW-1:0] ALU_SUB   = 2'b10;
  localparam logic [ALUW-1:0] ALU_INC   = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic            mem_rq;
    logic            rnw;
    logic            xsel;
    logic            ysel;
    logic [ALUW-1:0] alufs;
    logic            acc_en;
    logic            pc_en;
    logic            ir_en;
    logic            acc_oe;
    logic            halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mu0_control_if.sv
// Controller <-> datapath/memory signal bundle. master = sequencer side,
// slave = datapath side.
interface mu0_control_if;
  import mu0_pkg::*;

  logic [OPW-1:0]  F;
  logic            N;
  logic            Z;
  logic            MemAck;
  logic            MemRq;
  logic            RnW;
  logic            Xsel;
  logic            Ysel;
  logic [ALUW-1:0] ALUfs;
  logic            AccEn;
  logic            PCEn;
  logic            IREn;
  logic            AccOE;
  logic            Halted;
  logic            MemTimeout;

  modport master (
    input  F, N, Z, MemAck,
    output MemRq, RnW, Xsel, Ysel, ALUfs, AccEn, PCEn, IREn, AccOE, Halted, MemTimeout
  );

  modport slave (
    output F, N, Z, MemAck,
    input  MemRq, RnW, Xsel, Ysel, ALUfs, AccEn, PCEn, IREn, AccOE, Halted, MemTimeout
  );

endinterface

// File: rtl/mu0_decode.sv
// Purely combinational EXEC-phase control decode from opcode, flags and ack.
// Memory-backed enables are gated by ack so registers load only once data is valid.
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [OPW-1:0] i_f,
  input  logic           i_n,
  input  logic           i_z,
  input  logic           i_mem_ack,
  output ctrl_t          o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_f)
      OP_LDA: begin
        o_ctrl.mem_rq = 1'b1;
        o_ctrl.rnw    = 1'b1;
        o_ctrl.xsel   = 1'b1;
        o_ctrl.alufs  = ALU_PASSB;
        o_ctrl.acc_en = i_mem_ack;
      end
      OP_STA: begin
        o_ctrl.mem_rq = 1'b1;
        o_ctrl.rnw    = 1'b0;
        o_ctrl.xsel   = 1'b1;
        o_ctrl.acc_oe = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        o_ctrl.mem_rq = 1'b1;
        o_ctrl.rnw    = 1'b1;
        o_ctrl.xsel   = 1'b1;
        o_ctrl.ysel   = 1'b0;
        o_ctrl.alufs  = (i_f == OP_ADD) ? ALU_ADD : ALU_SUB;
        o_ctrl.acc_en = i_mem_ack;
      end
      // Jumps pass IR[11:0] through the ALU into PC; no memory cycle
      OP_JMP, OP_JGE, OP_JNE: begin
        o_ctrl.xsel  = 1'b1;
        o_ctrl.alufs = ALU_PASSB;
        o_ctrl.pc_en = (i_f == OP_JMP) ? 1'b1 :
                       (i_f == OP_JGE) ? ~i_n : ~i_z;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer with memory wait states and a sticky timeout.
// Optional MU0_INSTR_COUNT_EN adds a 16-bit completed-instruction counter.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
)(
  input  logic          Clk,
  input  logic          Reset,
  mu0_control_if.master bus
`ifdef MU0_INSTR_COUNT_EN
  ,
  output logic [ICW-1:0] InstrCount
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [WAITW-1:0] r_wait;
  logic             r_timeout;
  logic             w_wait_inc;
  logic             w_timeout_hit;
  ctrl_t            w_dec;
  ctrl_t            w_out;

  mu0_decode u_decode (
    .i_f       (bus.F),
    .i_n       (bus.N),
    .i_z       (bus.Z),
    .i_mem_ack (bus.MemAck),
    .o_ctrl    (w_dec)
  );

  // State register, wait counter and sticky timeout
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_FETCH;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= '0;
      else if (w_wait_inc)
        r_wait <= r_wait + WAITW'(1);
      if (w_timeout_hit)
        r_timeout <= 1'b1;
    end
  end

  // Next state: memory states wait for ack, bounded by MAX_WAIT wait cycles
  always_comb begin
    w_next        = r_state;
    w_wait_inc    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_FETCH, ST_EXEC: begin
        if (r_state == ST_EXEC && !w_dec.mem_rq) begin
          w_next = (bus.F == OP_STP) ? ST_HALT : ST_FETCH;
        end else if (bus.MemAck) begin
          w_next = (r_state == ST_FETCH) ? ST_EXEC : ST_FETCH;
        end else if (r_wait == WAITW'(MAX_WAIT - 1)) begin
          w_next        = ST_HALT;
          w_timeout_hit = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_HALT;
    endcase
  end

  // Output decode; Reset overrides everything
  always_comb begin
    w_out = CTRL_IDLE;
    case (r_state)
      ST_FETCH: begin
        w_out.mem_rq = 1'b1;
        w_out.rnw    = 1'b1;
        w_out.xsel   = 1'b0;
        w_out.ysel   = 1'b1;
        w_out.alufs  = ALU_INC;
        w_out.pc_en  = bus.MemAck;
        w_out.ir_en  = bus.MemAck;
      end
      ST_EXEC: w_out = w_dec;
      ST_HALT: w_out.halted = 1'b1;
      default: ;
    endcase
    if (Reset)
      w_out = CTRL_IDLE;
  end

  assign bus.MemRq      = w_out.mem_rq;
  assign bus.RnW        = w_out.rnw;
  assign bus.Xsel       = w_out.xsel;
  assign bus.Ysel       = w_out.ysel;
  assign bus.ALUfs      = w_out.alufs;
  assign bus.AccEn      = w_out.acc_en;
  assign bus.PCEn       = w_out.pc_en;
  assign bus.IREn       = w_out.ir_en;
  assign bus.AccOE      = w_out.acc_oe;
  assign bus.Halted     = w_out.halted;
  assign bus.MemTimeout = r_timeout & ~Reset;

`ifdef MU0_INSTR_COUNT_EN
  logic [ICW-1:0] r_icount;
  logic           w_instr_done;

  // Completed EXEC of a real opcode (0..7); NOPs and timeouts don't count
  assign w_instr_done = (r_state == ST_EXEC) && (w_next != ST_EXEC) &&
                        !w_timeout_hit && !bus.F[OPW-1];

  always_ff @(posedge Clk) begin
    if (Reset)
      r_icount <= '0;
    else if (w_instr_done)
      r_icount <= r_icount + ICW'(1);
  end

  assign InstrCount = r_icount;
`endif

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: per-cycle expected control words are
// queued on drive and popped against the DUT outputs mid-cycle.
module tb_mu0_control;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mu0_control_if bus();

`ifdef MU0_INSTR_COUNT_EN
  logic [15:0] InstrCount;
`endif

  mu0_control #(.MAX_WAIT(15)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
`ifdef MU0_INSTR_COUNT_EN
    ,
    .InstrCount (InstrCount)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [15:0] sb_q[$];

  // {MemRq,RnW,Xsel,Ysel,ALUfs,AccEn,PCEn,IREn,AccOE,Halted,MemTimeout}
  wire [11:0] w_obs = {bus.MemRq, bus.RnW, bus.Xsel, bus.Ysel, bus.ALUfs,
                       bus.AccEn, bus.PCEn, bus.IREn, bus.AccOE, bus.Halted,
                       bus.MemTimeout};

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] cv(input bit mrq, input bit rnw, input bit xs, input bit ys,
                                     input logic [1:0] alu, input bit acc, input bit pc,
                                     input bit ir, input bit oe, input bit h, input bit to);
    return {mrq, rnw, xs, ys, alu, acc, pc, ir, oe, h, to};
  endfunction

  localparam logic [11:0] ZERO = 12'h000;
  logic [11:0] FETCH_WAIT, FETCH_ACK, LDA_ACK, ADD_ACK, SUB_ACK, STA_V;
  logic [11:0] JMP_TAKEN, JMP_NOT, HALTED_V, HALT_TO;

  // Drive one cycle of inputs, queue the expected word, then compare
  task automatic cyc(input string tag, input logic rst, input logic [3:0] f,
                     input logic n, input logic z, input logic ack, input logic [11:0] exp);
    @(negedge Clk);
    Reset      = rst;
    bus.F      = f;
    bus.N      = n;
    bus.Z      = z;
    bus.MemAck = ack;
    sb_q.push_back({4'h0, exp});
    #2;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_val(tag, {4'h0, w_obs}, sb_q.pop_front());
    end
  endtask

  initial begin
    FETCH_WAIT = cv(1,1,0,1,2'b11,0,0,0,0,0,0);
    FETCH_ACK  = cv(1,1,0,1,2'b11,0,1,1,0,0,0);
    LDA_ACK    = cv(1,1,1,0,2'b00,1,0,0,0,0,0);
    ADD_ACK    = cv(1,1,1,0,2'b01,1,0,0,0,0,0);
    SUB_ACK    = cv(1,1,1,0,2'b10,1,0,0,0,0,0);
    STA_V      = cv(1,0,1,0,2'b00,0,0,0,1,0,0);
    JMP_TAKEN  = cv(0,0,1,0,2'b00,0,1,0,0,0,0);
    JMP_NOT    = cv(0,0,1,0,2'b00,0,0,0,0,0,0);
    HALTED_V   = cv(0,0,0,0,2'b00,0,0,0,0,1,0);
    HALT_TO    = cv(0,0,0,0,2'b00,0,0,0,0,1,1);

    Reset = 1'b1; bus.F = 4'd0; bus.N = 1'b0; bus.Z = 1'b0; bus.MemAck = 1'b1;

    cyc("reset0", 1, 4'd0, 0, 0, 1, ZERO);
    cyc("reset1", 1, 4'd0, 0, 0, 1, ZERO);

    cyc("fetch_lda", 0, 4'd0, 0, 0, 1, FETCH_ACK);
    cyc("exec_lda",  0, 4'd0, 0, 0, 1, LDA_ACK);
    cyc("fetch_jne", 0, 4'd6, 0, 1, 1, FETCH_ACK);
    cyc("jne_z1",    0, 4'd6, 0, 1, 1, JMP_NOT);
    cyc("fetch_jne2",0, 4'd6, 0, 0, 1, FETCH_ACK);
    cyc("jne_z0",    0, 4'd6, 0, 0, 1, JMP_TAKEN);
    cyc("fetch_jge", 0, 4'd5, 1, 0, 1, FETCH_ACK);
    cyc("jge_n1",    0, 4'd5, 1, 0, 1, JMP_NOT);
    cyc("fetch_jge2",0, 4'd5, 0, 0, 1, FETCH_ACK);
    cyc("jge_n0",    0, 4'd5, 0, 0, 1, JMP_TAKEN);
    cyc("fetch_jmp", 0, 4'd4, 0, 0, 1, FETCH_ACK);
    cyc("jmp",       0, 4'd4, 0, 0, 1, JMP_TAKEN);
    cyc("fetch_add", 0, 4'd2, 0, 0, 1, FETCH_ACK);
    cyc("exec_add",  0, 4'd2, 0, 0, 1, ADD_ACK);
    cyc("fetch_sub", 0, 4'd3, 0, 0, 1, FETCH_ACK);
    cyc("exec_sub",  0, 4'd3, 0, 0, 1, SUB_ACK);

    cyc("fetch_sta", 0, 4'd1, 0, 0, 1, FETCH_ACK);
    for (int i = 0; i < 3; i++) cyc("sta_wait", 0, 4'd1, 0, 0, 0, STA_V);
    cyc("sta_ack",   0, 4'd1, 0, 0, 1, STA_V);

    cyc("fetch_nop", 0, 4'd9, 0, 0, 1, FETCH_ACK);
    cyc("exec_nop",  0, 4'd9, 0, 0, 1, ZERO);

    for (int i = 0; i < 2; i++) cyc("fetch_wait", 0, 4'd7, 0, 0, 0, FETCH_WAIT);
    cyc("fetch_stp", 0, 4'd7, 0, 0, 1, FETCH_ACK);
    cyc("exec_stp",  0, 4'd7, 0, 0, 1, ZERO);
    for (int i = 0; i < 20; i++) cyc("halted", 0, 4'd0, 0, 0, 1, HALTED_V);

    cyc("reset_halt", 1, 4'd0, 0, 0, 0, ZERO);
    for (int i = 0; i < 15; i++) cyc("to_wait", 0, 4'd0, 0, 0, 0, FETCH_WAIT);
    for (int i = 0; i < 4; i++) cyc("timeout", 0, 4'd0, 0, 0, 1, HALT_TO);

    cyc("reset_to", 1, 4'd0, 0, 0, 1, ZERO);
    cyc("post_reset", 0, 4'd0, 0, 0, 0, FETCH_WAIT);
    cyc("reset_cnt", 1, 4'd0, 0, 0, 1, ZERO);

`ifdef MU0_INSTR_COUNT_EN
    check_val("icount_reset", InstrCount, 16'd0);
`endif
    cyc("p_f_lda", 0, 4'd0, 0, 0, 1, FETCH_ACK);
    cyc("p_x_lda", 0, 4'd0, 0, 0, 1, LDA_ACK);
    cyc("p_f_add", 0, 4'd2, 0, 0, 1, FETCH_ACK);
    cyc("p_x_add", 0, 4'd2, 0, 0, 1, ADD_ACK);
    cyc("p_f_sta", 0, 4'd1, 0, 0, 1, FETCH_ACK);
    cyc("p_x_sta", 0, 4'd1, 0, 0, 1, STA_V);
    cyc("p_f_jmp", 0, 4'd4, 0, 0, 1, FETCH_ACK);
    cyc("p_x_jmp", 0, 4'd4, 0, 0, 1, JMP_TAKEN);
    cyc("p_f_stp", 0, 4'd7, 0, 0, 1, FETCH_ACK);
    cyc("p_x_stp", 0, 4'd7, 0, 0, 1, ZERO);
    cyc("p_halt",  0, 4'd0, 0, 0, 1, HALTED_V);
`ifdef MU0_INSTR_COUNT_EN
    check_val("icount_5", InstrCount, 16'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
